// File: rtl/sccomp_dbg_ctrl.sv
// sccomp_dbg_ctrl: run/halt/step/breakpoint/register-dump sequencer in front of the sccomp CPU
module sccomp_dbg_ctrl #(
  parameter int PC_W       = 32,
  parameter int N_BRK      = 4,
  parameter int RST_CYCLES = 2,
  parameter int NREG       = 32,
  parameter int CNT_W      = 32,
  parameter bit AUTO_RUN   = 1'b1,
  parameter int BI_W       = (N_BRK > 1) ? $clog2(N_BRK) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [BI_W-1:0]  cmd_idx,
  input  logic [PC_W-1:0]  cmd_arg,
  output logic             cpu_rstn,
  output logic             cpu_ce,
  input  logic [PC_W-1:0]  cpu_pc,
  output logic [4:0]       reg_sel,
  input  logic [31:0]      reg_data,
  output logic             dump_valid,
  output logic [4:0]       dump_idx,
  output logic [31:0]      dump_data,
  output logic             halted,
  output logic             brk_hit,
  output logic [BI_W-1:0]  brk_id,
  output logic [CNT_W-1:0] cycle_cnt
);
  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam int NS = 2 ** BI_W;
  localparam logic [2:0] OP_RUN = 3'd1, OP_HALT = 3'd2, OP_STEP = 3'd3, OP_SET = 3'd4,
                         OP_CLR = 3'd5, OP_RCPU = 3'd6, OP_DUMP = 3'd7;
  typedef enum logic [2:0] {RST_HOLD, HALTED, RUN, STEP, DUMP} state_t;
  state_t           r_state;
  logic [HW-1:0]    r_hold;
  logic [PC_W-1:0]  r_bp_addr [NS];
  logic [NS-1:0]    r_bp_en;
  logic             r_skip_bp;
  logic             r_brk_hit;
  logic [BI_W-1:0]  r_brk_id;
  logic [4:0]       r_sel;
  logic             r_dv;
  logic [4:0]       r_didx;
  logic [31:0]      r_ddata;
  logic [CNT_W-1:0] r_cnt;
  logic             w_any;
  logic [BI_W-1:0]  w_hit_id;
  logic             w_bp_match;
  logic             w_acc;
  // Descending scan so the lowest matching slot is the one left in w_hit_id.
  always_comb begin
    w_any = 1'b0;
    w_hit_id = '0;
    for (int i = NS - 1; i >= 0; i--)
      if (i < N_BRK && r_bp_en[i] && r_bp_addr[i] == cpu_pc) begin
        w_any = 1'b1;
        w_hit_id = BI_W'(i);
      end
  end
  assign w_bp_match = w_any && !r_skip_bp;
  assign cmd_ready  = r_state == HALTED || r_state == RUN;
  assign w_acc      = cmd_valid && cmd_ready;
  assign cpu_rstn   = r_state != RST_HOLD;
  assign cpu_ce     = r_state == RST_HOLD || r_state == STEP || (r_state == RUN && !w_bp_match);
  assign halted     = r_state == HALTED;
  assign reg_sel    = r_sel;
  assign dump_valid = r_dv;
  assign dump_idx   = r_didx;
  assign dump_data  = r_ddata;
  assign brk_hit    = r_brk_hit;
  assign brk_id     = r_brk_id;
  assign cycle_cnt  = r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RST_HOLD;
      r_hold    <= HW'(RST_CYCLES);
      r_bp_en   <= '0;
      r_skip_bp <= 1'b0;
      r_brk_hit <= 1'b0;
      r_brk_id  <= '0;
      r_sel     <= '0;
      r_dv      <= 1'b0;
      r_didx    <= '0;
      r_ddata   <= '0;
      r_cnt     <= '0;
    end else begin
      r_dv <= r_state == DUMP;
      if (r_state == DUMP) begin
        r_didx  <= r_sel;
        r_ddata <= reg_data;
      end
      if (cpu_ce && cpu_rstn && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      if (w_acc && (cmd_op == OP_SET || cmd_op == OP_CLR)) r_bp_en[cmd_idx] <= cmd_op == OP_SET;
      if (w_acc && cmd_op == OP_SET) r_bp_addr[cmd_idx] <= cmd_arg;
      case (r_state)
        RST_HOLD: begin
          if (r_hold == HW'(1)) r_state <= AUTO_RUN ? RUN : HALTED;
          else r_hold <= r_hold - 1'b1;
        end
        HALTED: begin
          if (w_acc && cmd_op == OP_RUN) begin
            r_state   <= RUN;
            r_skip_bp <= 1'b1;
            r_brk_hit <= 1'b0;
          end
          if (w_acc && cmd_op == OP_STEP) begin
            r_state   <= STEP;
            r_brk_hit <= 1'b0;
          end
          if (w_acc && cmd_op == OP_DUMP) r_state <= DUMP;
        end
        RUN: begin
          r_skip_bp <= 1'b0;
          if (w_bp_match) begin
            r_state   <= HALTED;
            r_brk_hit <= 1'b1;
            r_brk_id  <= w_hit_id;
          end else if (w_acc && cmd_op == OP_HALT) begin
            r_state   <= HALTED;
            r_brk_hit <= 1'b0;
          end
        end
        STEP: r_state <= HALTED;
        DUMP: begin
          if (r_sel == 5'(NREG - 1)) begin
            r_state <= HALTED;
            r_sel   <= '0;
          end else r_sel <= r_sel + 1'b1;
        end
        default: r_state <= RST_HOLD;
      endcase
      if (w_acc && cmd_op == OP_RCPU) begin
        r_state   <= RST_HOLD;
        r_hold    <= HW'(RST_CYCLES);
        r_cnt     <= '0;
        r_brk_hit <= 1'b0;
        r_skip_bp <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sccomp_dbg_ctrl.sv
// tb_sccomp_dbg_ctrl: directed bench with a tiny CPU model and queue-based dump/halt scoreboards
module tb_sccomp_dbg_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [1:0]  cmd_idx = 2'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        cpu_rstn, cpu_ce;
  logic [31:0] pc = 32'd0;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        dump_valid;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        halted, brk_hit;
  logic [1:0]  brk_id;
  logic [31:0] cycle_cnt;
  logic [31:0] regs [32];

  typedef struct {logic hit; logic [1:0] id; logic [31:0] pc;} hexp_t;
  logic [36:0] dq[$];
  hexp_t       hq[$];
  int n_chk = 0, n_pass = 0;
  int run_len = 0, last_run = 0;
  logic prev_h = 1'b0;

  sccomp_dbg_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .cpu_rstn(cpu_rstn), .cpu_ce(cpu_ce), .cpu_pc(pc),
    .reg_sel(reg_sel), .reg_data(reg_data), .dump_valid(dump_valid), .dump_idx(dump_idx),
    .dump_data(dump_data), .halted(halted), .brk_hit(brk_hit), .brk_id(brk_id),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pc <= !cpu_rstn ? 32'd0 : cpu_ce ? pc + 32'd4 : pc;
  assign reg_data = regs[reg_sel];

  function automatic logic [31:0] exp_reg(input int i);
    return i == 0 ? 32'h0 : i == 7 ? 32'h1234 : 32'hA000_0000 | i;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] idx, input logic [31:0] arg);
    int n = 0;
    cmd_op = op; cmd_idx = idx; cmd_arg = arg; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (cmd_ready) tick();
    else begin n_chk++; $display("FAIL cmd_accept: op %0d never accepted, required within 50 cycles", op); end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_pc(input string name, input logic [31:0] p);
    int n = 0;
    while (!(cpu_rstn && !halted && pc == p) && n < 200) begin tick(); n++; end
    chk(name, pc, p);
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 200) begin tick(); n++; end
    chk(name, halted, 1);
  endtask

  // Monitor: pops expectations whenever the DUT presents a dump beat or newly halts.
  initial forever begin
    @(negedge clk);
    if (dump_valid) begin
      run_len++;
      if (dq.size() == 0) begin n_chk++; $display("FAIL dump_extra: idx %0d unexpected", dump_idx); end
      else begin
        logic [36:0] e;
        e = dq.pop_front();
        chk("dump_idx", dump_idx, e[36:32]);
        chk("dump_data", dump_data, e[31:0]);
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
    if (halted && !prev_h) begin
      if (hq.size() == 0) begin n_chk++; $display("FAIL halt_extra: unexpected halt at pc 0x%0h", pc); end
      else begin
        hexp_t h;
        h = hq.pop_front();
        chk("halt_brk_hit", brk_hit, h.hit);
        if (h.hit) chk("halt_brk_id", brk_id, h.id);
        chk("halt_pc", pc, h.pc);
      end
    end
    prev_h = halted;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic bad;
    int n;
    for (int i = 0; i < 32; i++) regs[i] = exp_reg(i);
    repeat (3) tick();
    chk("rst_rstn", cpu_rstn, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_dv", dump_valid, 0);
    chk("rst_regsel", reg_sel, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    tick(); chk("hold_rstn", cpu_rstn, 0);
    tick(); chk("run_rstn", cpu_rstn, 1); chk("run_ce", cpu_ce, 1); chk("run_cnt0", cycle_cnt, 0);
    for (int k = 1; k <= 3; k++) begin tick(); chk("run_cnt", cycle_cnt, k); end
    chk("run_not_halted", halted, 0);
    // Breakpoint at 0x0C, then RESET_CPU: slot survives, counter restarts.
    send(3'd4, 2'd1, 32'h0C);
    hq.push_back('{1'b1, 2'd1, 32'h0C});
    send(3'd6, 2'd0, 32'd0);
    chk("rcpu_cnt", cycle_cnt, 0);
    wait_halt("bp_halt");
    chk("bp_cnt", cycle_cnt, 3);
    repeat (3) tick();
    chk("cnt_frozen", cycle_cnt, 3);
    chk("pc_frozen", pc, 32'h0C);
    // STEP executes exactly one instruction.
    hq.push_back('{1'b0, 2'd0, 32'h10});
    send(3'd3, 2'd0, 32'd0);
    chk("step_ce", cpu_ce, 1);
    tick();
    chk("step_halted", halted, 1);
    chk("step_cnt", cycle_cnt, 4);
    // RUN from a breakpointed PC must not re-hit immediately.
    send(3'd4, 2'd0, 32'h10);
    send(3'd1, 2'd0, 32'd0);
    chk("skip_ce", cpu_ce, 1);
    tick();
    chk("no_rehit_halted", halted, 0);
    chk("no_rehit_pc", pc, 32'h14);
    // HALT in the same cycle as a match at 0x08: breakpoint wins.
    send(3'd4, 2'd2, 32'h08);
    hq.push_back('{1'b1, 2'd2, 32'h08});
    send(3'd6, 2'd0, 32'd0);
    wait_pc("reach_08", 32'h08);
    chk("halt_bp_ready", cmd_ready, 1);
    cmd_op = 3'd2; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("halt_bp_halted", halted, 1);
    chk("halt_bp_hit", brk_hit, 1);
    // Cleared slots are passed over; plain HALT lets one more instruction run.
    send(3'd5, 2'd1, 32'd0);
    send(3'd5, 2'd0, 32'd0);
    send(3'd1, 2'd0, 32'd0);
    wait_pc("reach_18", 32'h18);
    hq.push_back('{1'b0, 2'd0, 32'h1C});
    send(3'd2, 2'd0, 32'd0);
    chk("halt_plain_hit", brk_hit, 0);
    // Full register dump.
    for (int i = 0; i < 32; i++) dq.push_back({5'(i), exp_reg(i)});
    hq.push_back('{1'b0, 2'd0, 32'h1C});
    send(3'd7, 2'd0, 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (cmd_ready || cpu_ce) bad = 1'b1;
      tick();
    end
    chk("dump_ready_low", bad, 0);
    chk("dump_done_halted", halted, 1);
    repeat (2) tick();
    chk("dump_run_len", last_run, 32);
    chk("dump_all_seen", dq.size(), 0);
    chk("dump_regsel0", reg_sel, 0);
    // rst while dumping idx 10.
    for (int i = 0; i < 10; i++) dq.push_back({5'(i), exp_reg(i)});
    send(3'd7, 2'd0, 32'd0);
    n = 0;
    while (reg_sel != 5'd10 && n < 100) begin tick(); n++; end
    chk("mid_dump_sel", reg_sel, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_dv", dump_valid, 0);
    chk("mid_rst_regsel", reg_sel, 0);
    chk("mid_rst_rstn", cpu_rstn, 0);
    chk("mid_rst_cnt", cycle_cnt, 0);
    chk("mid_rst_dq", dq.size(), 0);
    wait_pc("bp_cleared_pc", 32'h20);
    chk("bp_cleared_halted", halted, 0);
    chk("halt_all_seen", hq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
